// File: rtl/counter_sequencer.sv
// counter_sequencer: start/stop/pause controlled up-counter with one-shot or auto-reload terminal count
module counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int PWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              auto_reload,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count_out,
    output logic [1:0]        state_out,
    output logic              busy,
    output logic              done,
    output logic              tc_pulse,
    output logic [PWIDTH-1:0] periods
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;
    state_t           state;
    logic [WIDTH-1:0] limit_q;
    logic             reload_q;
    logic             launch;
    assign launch    = start && (limit != '0);
    assign state_out = state;
    assign busy      = (state == RUN) || (state == HOLD);
    assign done      = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count_out <= '0;
            periods   <= '0;
            tc_pulse  <= 1'b0;
            limit_q   <= '0;
            reload_q  <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            count_out <= '0;
            periods   <= '0;
            tc_pulse  <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            case (state)
                IDLE, DONE: if (launch) begin
                    limit_q   <= limit;
                    reload_q  <= auto_reload;
                    periods   <= '0;
                    count_out <= '0;
                    state     <= RUN;
                end
                RUN: if (pause) state <= HOLD;
                    else if (count_out == limit_q) begin
                        tc_pulse <= 1'b1;
                        periods  <= periods + 1'b1;
                        if (reload_q) count_out <= '0;
                        else state <= DONE;
                    end else count_out <= count_out + 1'b1;
                HOLD: if (!pause) state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and random checks of counter_sequencer against a behavioural model
module tb_counter_sequencer;
    localparam int W = 4, PW = 4;
    logic clk = 0, rst = 1, start = 0, stop = 0, pause = 0, auto_reload = 0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count_out;
    logic [1:0] state_out;
    logic busy, done, tc_pulse;
    logic [PW-1:0] periods;
    int vectors = 0, miscompares = 0;
    bit running, holding, finished, m_reload, m_tc;
    int m_count, m_periods, m_lim;
    always #5 clk = ~clk;
    counter_sequencer #(.WIDTH(W), .PWIDTH(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .limit(limit), .count_out(count_out),
        .state_out(state_out), .busy(busy), .done(done), .tc_pulse(tc_pulse),
        .periods(periods)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        running = 0; holding = 0; finished = 0; m_reload = 0; m_tc = 0;
        m_count = 0; m_periods = 0; m_lim = 0;
    endtask
    // One clock edge of the counter described in plain terms: modes plus a counter value.
    task automatic model_step();
        bit tc_n = 0;
        if (stop) begin
            running = 0; holding = 0; finished = 0; m_count = 0; m_periods = 0;
        end else if (!running && !holding) begin
            if (start && limit != 0) begin
                m_lim = limit; m_reload = auto_reload; m_periods = 0; m_count = 0;
                running = 1; finished = 0;
            end
        end else if (holding) begin
            if (!pause) begin holding = 0; running = 1; end
        end else if (pause) begin
            running = 0; holding = 1;
        end else if (m_count == m_lim) begin
            tc_n = 1;
            m_periods = (m_periods + 1) % (1 << PW);
            if (m_reload) m_count = 0;
            else begin running = 0; finished = 1; end
        end else m_count++;
        m_tc = tc_n;
    endtask
    task automatic check_model();
        int st = running ? 1 : holding ? 2 : finished ? 3 : 0;
        chk("count", count_out, m_count);
        chk("state", state_out, st);
        chk("busy", busy, running || holding);
        chk("done", done, finished);
        chk("tc", tc_pulse, m_tc);
        chk("periods", periods, m_periods);
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        check_model();
        @(negedge clk);
    endtask
    initial begin
        int tcs;
        #2;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 0;
        // one-shot to limit 3
        limit = 3; auto_reload = 0; start = 1;
        tick();
        start = 0;
        chk("t1 count0", count_out, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("t1 count", count_out, i);
            chk("t1 tc low", tc_pulse, 0);
        end
        tick();
        chk("t1 tc", tc_pulse, 1);
        chk("t1 state", state_out, 3);
        chk("t1 periods", periods, 1);
        tick();
        chk("t1 tc once", tc_pulse, 0);
        chk("t1 hold", count_out, 3);
        chk("t1 done", done, 1);
        // auto-reload at limit 2
        limit = 2; auto_reload = 1; start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("t2 count", count_out, i % 3);
            chk("t2 tc", tc_pulse, (i % 3) == 0);
            chk("t2 periods", periods, i / 3);
            chk("t2 busy", busy, 1);
        end
        // pause at count 4
        stop = 1;
        tick();
        stop = 0; limit = 9; auto_reload = 0; start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        pause = 1;
        repeat (3) begin
            tick();
            chk("t3 hold state", state_out, 2);
            chk("t3 hold count", count_out, 4);
        end
        pause = 0;
        tick();
        chk("t3 resume", state_out, 1);
        tick();
        chk("t3 count5", count_out, 5);
        tick();
        chk("t3 count6", count_out, 6);
        // stop beats start; limit 0 ignored
        stop = 1; start = 1;
        tick();
        chk("t4 state", state_out, 0);
        chk("t4 count", count_out, 0);
        chk("t4 periods", periods, 0);
        stop = 0; limit = 0;
        tick();
        chk("t4 limit0", state_out, 0);
        start = 0;
        // async reset mid-run at count 5
        limit = 9; start = 1;
        tick();
        start = 0; limit = 2;
        repeat (5) tick();
        chk("t5 pre", count_out, 5);
        #2 rst = 1;
        #1 model_reset();
        check_model();
        chk("t5 state", state_out, 0);
        @(negedge clk);
        rst = 0;
        repeat (3) tick();
        chk("t5 idle", state_out, 0);
        // wrap at full-scale limit
        limit = 15; auto_reload = 1; start = 1;
        tick();
        start = 0;
        tcs = tc_pulse;
        repeat (32) begin
            tick();
            tcs += tc_pulse;
        end
        chk("t6 tc count", tcs, 2);
        stop = 1;
        tick();
        stop = 0; limit = 1; auto_reload = 0; start = 1;
        tick();
        start = 0;
        tick();
        chk("t6 count1", count_out, 1);
        tick();
        chk("t6 done", state_out, 3);
        start = 1;
        tick();
        start = 0;
        chk("t6 restart", state_out, 1);
        chk("t6 restart count", count_out, 0);
        tick();
        tick();
        chk("t6 done again", state_out, 3);
        // periods wrap
        limit = 1; auto_reload = 1; start = 1;
        tick();
        start = 0;
        repeat (40) tick();
        chk("periods wrap", periods, 4);
        // random traffic
        repeat (600) begin
            stop = $urandom_range(0, 19) == 0;
            start = $urandom_range(0, 3) == 0;
            pause = $urandom_range(0, 4) == 0;
            auto_reload = 1'($urandom);
            limit = W'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1;
                #1 model_reset();
                check_model();
                @(negedge clk);
                rst = 0;
            end else tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
